// File: rtl/bist_march_controller.sv
// March C- BIST sequencer: drives SRAM address/data/strobes, feeds the comparator, logs mismatches.
// Optional STOP_ON_FAIL_EN: end the run on the first mismatch instead of completing all elements.
module bist_march_controller #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              cmp_eq,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [CNT_W-1:0]  fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        LAST_ELEM = 3'd5;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        elem;
    logic [2:0]        elem_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              walk_down;
    logic              elem_end;
    logic              advance;
    logic              mismatch;
    logic              restart;

    // Elements 3 and 4 walk downward; every other element walks upward.
    always_comb begin
        walk_down = (elem == 3'd3) || (elem == 3'd4);
        elem_end  = walk_down ? (addr == '0) : (addr == ADDR_LAST);
        mismatch  = (state == S_CMP) && !cmp_eq;
        restart   = ((state == S_IDLE) || (state == S_DONE)) && start;
        advance   = (state == S_WR) || ((state == S_CMP) && (elem == LAST_ELEM));
    end

    // Address/element stepping is folded into the last op of each address, so it costs no cycle.
    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = addr;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_WR;
                    elem_nxt  = '0;
                    addr_nxt  = '0;
                end
            end
            S_RD:    state_nxt = S_CMP;
            S_CMP:   if (!advance) state_nxt = S_WR;
            S_WR:    state_nxt = S_WR;
            default: state_nxt = S_IDLE;
        endcase
        if (advance) begin
            if (elem_end) begin
                if (elem == LAST_ELEM) begin
                    state_nxt = S_DONE;
                end else begin
                    elem_nxt  = elem + 3'd1;
                    addr_nxt  = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : '0;
                    state_nxt = S_RD;
                end
            end else begin
                addr_nxt  = walk_down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                state_nxt = (elem == 3'd0) ? S_WR : S_RD;
            end
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch) state_nxt = S_DONE;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            elem  <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            addr  <= addr_nxt;
        end
    end

    // Only the first mismatch of a run records its location; the count keeps going and saturates.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            fail      <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
            if (!fail) begin
                fail_addr <= addr;
                fail_elem <= elem;
            end
        end
    end

    assign busy     = (state == S_WR) || (state == S_RD) || (state == S_CMP);
    assign done     = (state == S_DONE);
    assign mem_we   = (state == S_WR);
    assign mem_re   = (state == S_RD);
    assign mem_addr = busy ? addr : '0;

    // Odd elements write ones and read zeros; even elements the opposite.
    always_comb begin
        mem_data = '0;
        case (state)
            S_WR:        mem_data = {DATA_W{elem[0]}};
            S_RD, S_CMP: mem_data = {DATA_W{~elem[0]}};
            default:     mem_data = '0;
        endcase
    end

endmodule

// File: tb/tb_bist_march_controller.sv
// Randomized stuck-at fault bench for bist_march_controller with a behavioural SRAM/comparator.
// The expected op stream and fail log come from an abstract March C- model; a monitor scoreboards each strobe.
module tb_bist_march_controller;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_re;
    logic              cmp_eq;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [CNT_W-1:0]  fail_cnt;

    bist_march_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
        .cmp_eq(cmp_eq), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    op_t exp_q[$];
    op_t want;
    int  checks = 0;
    int  errors = 0;

    bit  f_en;
    int  f_addr;
    int  f_bit;
    bit  f_val;

    int  exp_cnt;
    int  exp_faddr;
    int  exp_felem;
    int  exp_cycles;
    bit  exp_fail;

    logic [DATA_W-1:0] sram [N];
    logic [DATA_W-1:0] ram_q;

    function automatic logic [DATA_W-1:0] faulty(input int a, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    // SRAM with one-cycle read and a single stuck-at cell; comparator is a plain equality.
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_data;
        if (mem_re) ram_q <= faulty(int'(mem_addr), sram[mem_addr]);
    end
    assign cmp_eq = (ram_q == mem_data);

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Walk the March C- elements over an abstract memory array to produce the op stream and fail log.
    function automatic void buildExpected();
        logic [DATA_W-1:0] mem [N];
        logic [DATA_W-1:0] bg;
        logic [DATA_W-1:0] rd;
        int rd_bg [6];
        int wr_bg [6];
        bit dn    [6];
        bit stop;
        int a;
        rd_bg = '{-1, 0, 1, 0, 1, 0};
        wr_bg = '{0, 1, 0, 1, 0, -1};
        dn    = '{0, 0, 0, 1, 1, 0};
        stop       = 1'b0;
        exp_cnt    = 0;
        exp_fail   = 1'b0;
        exp_faddr  = 0;
        exp_felem  = 0;
        exp_cycles = 0;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                if (stop) continue;
                a = dn[e] ? (N - 1 - i) : i;
                if (rd_bg[e] >= 0) begin
                    bg = (rd_bg[e] == 1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
                    exp_q.push_back('{1'b0, ADDR_W'(a), bg});
                    exp_cycles += 2;
                    rd = faulty(a, mem[a]);
                    if (rd != bg) begin
                        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                        if (!exp_fail) begin
                            exp_faddr = a;
                            exp_felem = e;
                        end
                        exp_fail = 1'b1;
`ifdef STOP_ON_FAIL_EN
                        stop = 1'b1;
`else
`endif
                    end
                end
                if (!stop && wr_bg[e] >= 0) begin
                    bg = (wr_bg[e] == 1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
                    exp_q.push_back('{1'b1, ADDR_W'(a), bg});
                    exp_cycles += 1;
                    mem[a] = bg;
                end
            end
        end
    endfunction

    // Scoreboard: every strobe cycle must match the next expected op in order.
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            checkOutput("strobe_exclusive", mem_we & mem_re, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_op: got we=%0b re=%0b addr=%0d data=%0h, expected no op",
                         mem_we, mem_re, mem_addr, mem_data);
            end else begin
                want = exp_q.pop_front();
                checks++;
                if ({mem_we, mem_addr, mem_data} !== want) begin
                    errors++;
                    $display("[TB] FAIL op_stream: got we=%0b addr=%0d data=%0h, expected we=%0b addr=%0d data=%0h",
                             mem_we, mem_addr, mem_data, want.is_wr, want.addr, want.data);
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_data"}, mem_data, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_re"}, mem_re, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_fail"}, fail, 0);
        checkOutput({tag, "_fail_addr"}, fail_addr, 0);
        checkOutput({tag, "_fail_elem"}, fail_elem, 0);
        checkOutput({tag, "_fail_cnt"}, fail_cnt, 0);
    endtask

    task automatic applyStimulus(input bit fault, input int fa, input int fb, input bit fv,
                                 input int mid_start);
        int  cyc;
        int  busy_cyc;
        bit  finished;
        f_en   = fault;
        f_addr = fa;
        f_bit  = fb;
        f_val  = fv;
        buildExpected();
        $display("[TB] run fault=%0b addr=%0d bit=%0d val=%0b mid_start=%0d", fault, fa, fb, fv, mid_start);
        @(negedge clk);
        start    = 1'b1;
        cyc      = 0;
        busy_cyc = 0;
        finished = 1'b0;
        while (!finished && cyc < 15 * N + 20) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start);
            if (cyc == 1) begin
                checkOutput("busy_after_start", busy, 1);
                checkOutput("fail_cleared", fail, 0);
                checkOutput("fail_cnt_cleared", fail_cnt, 0);
            end
            if (busy) busy_cyc++;
            if (done) finished = 1'b1;
        end
        start = 1'b0;
        checkOutput("run_finished", finished, 1);
        checkOutput("busy_cycles", busy_cyc, exp_cycles);
        checkOutput("busy_low_at_done", busy, 0);
        checkOutput("fail", fail, exp_fail);
        checkOutput("fail_cnt", fail_cnt, exp_cnt);
        checkOutput("fail_addr", fail_addr, exp_faddr);
        checkOutput("fail_elem", fail_elem, exp_felem);
        checkOutput("ops_remaining", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        checkOutput("done_held", done, 1);
    endtask

    task automatic abortRun(input int at_cycle);
        f_en = 1'b0;
        buildExpected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at_cycle - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("abort");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) sram[i] = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("idle");

        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1'b1, 5, 0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 50);
        abortRun(100);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, N - 1),
                          $urandom_range(0, DATA_W - 1), 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
